// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and latency table for the decode-side hazard scoreboard.
package hazard_scoreboard_pkg;

    localparam int NREG     = 16;
    localparam int REG_W    = 4;
    localparam int CNT_W    = 2;
    localparam int LOAD_LAT = 1;
    localparam int MUL_LAT  = 3;

    typedef enum logic [1:0] {
        LAT_ALU,
        LAT_LOAD,
        LAT_MUL,
        LAT_RSVD
    } lat_class_e;

    // Reserved class behaves as a multiply so unknown long ops stay safe.
    function automatic logic [CNT_W-1:0] lat_of(input lat_class_e c);
        case (c)
            LAT_ALU:  lat_of = '0;
            LAT_LOAD: lat_of = CNT_W'(LOAD_LAT);
            default:  lat_of = CNT_W'(MUL_LAT);
        endcase
    endfunction

endpackage

// File: rtl/hazard_scoreboard_counter.sv
// Per-entry countdown of cycles until a pending result becomes forwardable.
// Latency: busy reflects the register value; load takes effect on the next edge.
// Backpressure: none; load has priority over the self-decrement.
module reg_lat_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic         busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes and stalls decode on RAW, WAW and multiplier hazards.
// Latency: stall is combinational from decode fields; busy_mask/stall_cnt are registered.
// Backpressure: stall holds fetch/decode and injects an EX bubble; flush drops the decode slot.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_src_a,
    input  logic [REG_W-1:0]  id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic              id_wr_en,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [1:0]        id_lat,
    input  logic              ex_flush,
    output logic              stall,
    output logic [NREG-1:0]   busy_mask,
    output logic [15:0]       stall_cnt
);

    // Entries 0..NREG-1 are registers; entry NREG is the shared multiplier.
    logic [CNT_W-1:0] cnt [NREG+1];
    logic [NREG:0]    nz;
    logic [CNT_W-1:0] id_lat_cyc;
    logic             is_mul;
    logic             raw_a;
    logic             raw_b;
    logic             waw;
    logic             mul_hold;
    logic             issue;

    assign id_lat_cyc = lat_of(lat_class_e'(id_lat));
    assign is_mul     = id_lat[1];

    // Hazards read the pre-edge counters, so src == dest sees the older write.
    assign raw_a    = id_use_a & nz[{1'b0, id_src_a}];
    assign raw_b    = id_use_b & nz[{1'b0, id_src_b}];
    assign waw      = id_wr_en & (cnt[{1'b0, id_dest}] > id_lat_cyc);
    assign mul_hold = is_mul & nz[NREG];

    assign stall = rst_n & id_valid & ~ex_flush & (raw_a | raw_b | waw | mul_hold);
    assign issue = id_valid & ~stall & ~ex_flush;

    for (genvar r = 0; r <= NREG; r++) begin : g_cnt
        logic             ld;
        logic [CNT_W-1:0] ld_val;

        if (r < NREG) begin : g_reg
            assign ld     = issue & id_wr_en & (id_dest == REG_W'(r));
            assign ld_val = id_lat_cyc;
        end else begin : g_mul
            assign ld     = issue & is_mul;
            assign ld_val = CNT_W'(MUL_LAT);
        end

        reg_lat_counter #(.W(CNT_W)) u_cnt (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (ld),
            .load_val (ld_val),
            .cnt      (cnt[r]),
            .busy     (nz[r])
        );
    end

    assign busy_mask = nz[NREG-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule
